// File: rtl/ffd_pkg.sv
// Shared constants and helpers for the ffd_pipe register pipeline.
package ffd_pkg;

  localparam int FFD_WIDTH_DEFAULT = 8;
  localparam int FFD_DEPTH_DEFAULT = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/ffd_pipe_stage.sv
// One pipeline stage: a data register and a valid bit. The stage loads from
// upstream only when its advance enable is high.
module ffd_pipe_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic [WIDTH-1:0] upData,
  input  logic             upValid,
  output logic [WIDTH-1:0] data_q,
  output logic             valid_q
);

  // Data is written only for a valid upstream word, so a bubble that moves in
  // leaves the old data in place and only the valid bit drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else if (adv) begin
      valid_q <= upValid;
      if (upValid) begin
        data_q <= upData;
      end
    end
  end

endmodule

// File: rtl/ffd_pipe.sv
// WIDTH x DEPTH stallable register pipeline with valid/ready handshakes,
// bubble collapsing, synchronous flush and a registered occupancy count.
module ffd_pipe
  import ffd_pkg::*;
#(
  parameter int WIDTH = FFD_WIDTH_DEFAULT,
  parameter int DEPTH = FFD_DEPTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = clog2(DEPTH + 1);

  if (DEPTH < 1) begin : gDepthCheck
    $error("ffd_pipe: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stageData_q [DEPTH];
  logic [DEPTH-1:0] stageValid_q;
  logic [DEPTH-1:0] adv;
  logic             inXfer;
  logic             outXfer;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  // A stage advances unless it and every stage downstream of it is full while
  // the output is stalled; the running AND avoids a self-referencing chain.
  always_comb begin
    logic fullToEnd;
    fullToEnd = 1'b1;
    adv       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fullToEnd = fullToEnd & stageValid_q[i];
      adv[i]    = out_ready | ~fullToEnd;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    if (i == 0) begin : gFirst
      ffd_pipe_stage #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
      ) uStage (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .adv    (adv[i]),
        .upData (in_data),
        .upValid(in_valid),
        .data_q (stageData_q[i]),
        .valid_q(stageValid_q[i])
      );
    end else begin : gRest
      ffd_pipe_stage #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(RESET_VALUE)
      ) uStage (
        .clk    (clk),
        .reset  (reset),
        .flush  (flush),
        .adv    (adv[i]),
        .upData (stageData_q[i-1]),
        .upValid(stageValid_q[i-1]),
        .data_q (stageData_q[i]),
        .valid_q(stageValid_q[i])
      );
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = stageValid_q[DEPTH-1];
  assign out_data  = stageData_q[DEPTH-1];
  assign inXfer    = in_valid & in_ready;
  assign outXfer   = out_valid & out_ready;
  assign count_d   = count_q + CW'(inXfer) - CW'(outXfer);

  // Flush takes priority, so an output presented during flush is never counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_ffd_pipe.sv
// Directed self-checking bench for ffd_pipe: an 8x4 instance and an 8x1 instance.
module tb_ffd_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;

  logic [7:0] inData;
  logic       inValid;
  logic       inReady;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [2:0] count;

  logic [7:0] in1Data;
  logic       in1Valid;
  logic       in1Ready;
  logic [7:0] out1Data;
  logic       out1Valid;
  logic       out1Ready;
  logic [0:0] count1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ffd_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (inData),
    .in_valid (inValid),
    .in_ready (inReady),
    .out_data (outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .count    (count)
  );

  ffd_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in1Data),
    .in_valid (in1Valid),
    .in_ready (in1Ready),
    .out_data (out1Data),
    .out_valid(out1Valid),
    .out_ready(out1Ready),
    .count    (count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic ordy, input logic fl);
    inValid  = v;
    inData   = d;
    outReady = ordy;
    flush    = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    reset     = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    in1Data   = 8'h00;
    in1Valid  = 1'b0;
    out1Ready = 1'b0;

    // Reset state
    repeat (2) tick();
    checkOutput("rst_out_valid", 32'(outValid), 32'(0));
    checkOutput("rst_out_data", 32'(outData), 32'(8'h00));
    checkOutput("rst_count", 32'(count), 32'(0));
    checkOutput("rst_in_ready", 32'(inReady), 32'(1));
    reset = 1'b0;

    // Streaming 01..10 with out_ready held high
    for (int t = 1; t <= 20; t++) begin
      applyStimulus(t <= 16, 8'(t), 1'b1, 1'b0);
      tick();
      checkOutput("stream_valid", 32'(outValid), 32'(t >= 4 && t <= 19));
      if (t >= 4 && t <= 19) checkOutput("stream_data", 32'(outData), 32'(t - 3));
      if (t <= 16) checkOutput("stream_count", 32'(count), 32'((t < 4) ? t : 4));
    end
    checkOutput("stream_drained", 32'(count), 32'(0));

    // Back-pressure: fill A0..A3 with out_ready low
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0);
    #1;
    checkOutput("bp_count_full", 32'(count), 32'(4));
    checkOutput("bp_out_data", 32'(outData), 32'(8'hA0));
    checkOutput("bp_in_ready_low", 32'(inReady), 32'(0));
    tick();
    checkOutput("bp_hold_data", 32'(outData), 32'(8'hA0));
    checkOutput("bp_hold_count", 32'(count), 32'(4));
    applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0);
    #1;
    checkOutput("bp_in_ready_high", 32'(inReady), 32'(1));
    tick();
    checkOutput("bp_swap_count", 32'(count), 32'(4));
    checkOutput("bp_swap_data", 32'(outData), 32'(8'hA1));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("bp_drain_count", 32'(count), 32'(3));
    checkOutput("bp_drain_data", 32'(outData), 32'(8'hA2));
    repeat (3) tick();
    checkOutput("bp_empty_count", 32'(count), 32'(0));
    checkOutput("bp_empty_valid", 32'(outValid), 32'(0));

    // Bubble collapse: 11, two idle cycles, 22, with out_ready low
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("bub_count", 32'(count), 32'(2));
    checkOutput("bub_out_data", 32'(outData), 32'(8'h11));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("bub_next_data", 32'(outData), 32'(8'h22));
    checkOutput("bub_next_count", 32'(count), 32'(1));
    tick();
    checkOutput("bub_empty_count", 32'(count), 32'(0));

    // Flush with three words held, input valid and output ready
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h31 + 8'(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b1);
    #1;
    checkOutput("fl_in_ready", 32'(inReady), 32'(0));
    tick();
    checkOutput("fl_count", 32'(count), 32'(0));
    checkOutput("fl_out_valid", 32'(outValid), 32'(0));
    checkOutput("fl_out_data", 32'(outData), 32'(8'h00));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("fl_dropped_count", 32'(count), 32'(0));
    checkOutput("fl_dropped_valid", 32'(outValid), 32'(0));

    // Asynchronous reset with three words held
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h41 + 8'(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("ar_pre_data", 32'(outData), 32'(8'h41));
    checkOutput("ar_pre_count", 32'(count), 32'(3));
    reset = 1'b1;
    #1;
    checkOutput("ar_out_valid", 32'(outValid), 32'(0));
    checkOutput("ar_out_data", 32'(outData), 32'(8'h00));
    checkOutput("ar_count", 32'(count), 32'(0));
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("ar_lat_early", 32'(outValid), 32'(0));
    tick();
    checkOutput("ar_lat_valid", 32'(outValid), 32'(1));
    checkOutput("ar_lat_data", 32'(outData), 32'(8'h51));

    // DEPTH=1 build
    in1Valid  = 1'b1;
    in1Data   = 8'h5A;
    out1Ready = 1'b0;
    tick();
    in1Data = 8'h5B;
    #1;
    checkOutput("d1_out_data", 32'(out1Data), 32'(8'h5A));
    checkOutput("d1_count", 32'(count1), 32'(1));
    checkOutput("d1_in_ready_low", 32'(in1Ready), 32'(0));
    out1Ready = 1'b1;
    #1;
    checkOutput("d1_in_ready_high", 32'(in1Ready), 32'(1));
    tick();
    checkOutput("d1_next_data", 32'(out1Data), 32'(8'h5B));
    checkOutput("d1_next_count", 32'(count1), 32'(1));
    in1Valid = 1'b0;
    tick();
    checkOutput("d1_empty_valid", 32'(out1Valid), 32'(0));
    checkOutput("d1_empty_count", 32'(count1), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
